// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
// Writeback-side integer register file for the RV64 core. Holds x1..x31
// (x0 reads as zero, writes to it are dropped), serves two combinational read
// ports to the issuing instruction, and keeps a per-register load scoreboard
// that holds issue on RAW/WAW hazards against loads still in flight.
// The ALU result and the load response share a single write port; the ALU
// has priority and a colliding load response waits through ld_rsp_ready_o.
//
// Optional feature: define REGFILE_BYPASS_EN to forward this cycle's write
// data to the read ports and to let a busy bit being cleared this cycle
// count as clear for the stall decision.
// ---------------------------------------------------------------------------
module wb_regfile #(
   parameter int XLEN = 64,
   parameter int NREG = 32
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic [4:0]      rs1_addr_i,
   input  logic [4:0]      rs2_addr_i,
   input  logic            rs1_used_i,
   input  logic            rs2_used_i,
   output logic [XLEN-1:0] rs1_rdata_o,
   output logic [XLEN-1:0] rs2_rdata_o,
   input  logic [4:0]      rd_addr_i,
   input  logic            rd_wen_i,
   input  logic [XLEN-1:0] alu_res_i,
   input  logic            ld_issue_i,
   input  logic            ld_rsp_valid_i,
   output logic            ld_rsp_ready_o,
   input  logic [4:0]      ld_rsp_rd_i,
   input  logic [XLEN-1:0] ld_rsp_data_i,
   input  logic [1:0]      ld_rsp_size_i,
   input  logic            ld_rsp_unsigned_i,
   output logic            stall_o
);

   localparam int AW = 5;

   logic [XLEN-1:0] regs_q [1:NREG-1];
   logic [XLEN-1:0] regs_d [1:NREG-1];
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;

   logic [NREG-1:0] clearView;
   logic [NREG-1:0] busyView;
   logic            stall;
   logic            aluFire;
   logic            ldFire;
   logic            rspAccept;
   logic [XLEN-1:0] rspExt;
   logic            wrEn;
   logic [AW-1:0]   wrAddr;
   logic [XLEN-1:0] wrData;
   logic [XLEN-1:0] rs1Data;
   logic [XLEN-1:0] rs2Data;

   // Narrow the raw right-aligned load data to its access size and fill the
   // upper bits with either zeros or the top bit of the selected field.
   function automatic logic [XLEN-1:0] extendLoad(
      input logic [XLEN-1:0] raw,
      input logic [1:0]      size,
      input logic            isUnsigned
   );
      logic [XLEN-1:0] res;
      res = raw;
      case (size)
         2'd0:    res = {{(XLEN-8){~isUnsigned & raw[7]}}, raw[7:0]};
         2'd1:    res = {{(XLEN-16){~isUnsigned & raw[15]}}, raw[15:0]};
         2'd2:    res = {{(XLEN-32){~isUnsigned & raw[31]}}, raw[31:0]};
         default: res = raw;
      endcase
      return res;
   endfunction

   assign rspExt = extendLoad(ld_rsp_data_i, ld_rsp_size_i, ld_rsp_unsigned_i);

`ifdef REGFILE_BYPASS_EN
   // Busy bit the response is about to clear, seen early by the hazard check.
   // The clear is only forwarded when the issuing instruction is not an ALU
   // write to a real register: such an instruction would take the write port
   // if it issued and push the response out, so the clear could not happen.
   // Forwarding only in the safe case keeps stall and ready free of a loop.
   always_comb begin
      clearView = '0;
      if (ld_rsp_valid_i && !(rd_wen_i && rd_addr_i != '0) && ld_rsp_rd_i != '0) begin
         clearView[ld_rsp_rd_i] = 1'b1;
      end
   end
`else
   assign clearView = '0;
`endif

   assign busyView = busy_q & ~clearView;

   // Hold issue when any operand the instruction really reads, or the
   // register it is about to produce, still has a load outstanding.
   always_comb begin
      stall = 1'b0;
      if (rs1_used_i && busyView[rs1_addr_i]) begin
         stall = 1'b1;
      end
      if (rs2_used_i && busyView[rs2_addr_i]) begin
         stall = 1'b1;
      end
      if ((rd_wen_i || ld_issue_i) && busyView[rd_addr_i]) begin
         stall = 1'b1;
      end
   end

   assign stall_o        = stall;
   assign aluFire        = rd_wen_i & ~stall & (rd_addr_i != '0);
   assign ldFire         = ld_issue_i & ~stall & (rd_addr_i != '0);
   assign ld_rsp_ready_o = ~aluFire;
   assign rspAccept      = ld_rsp_valid_i & ld_rsp_ready_o;

   // Single write port arbitration: an issuing ALU write wins, otherwise an
   // accepted load response uses the port. Writes to x0 never reach it.
   always_comb begin
      wrEn   = 1'b0;
      wrAddr = '0;
      wrData = '0;
      if (aluFire) begin
         wrEn   = 1'b1;
         wrAddr = rd_addr_i;
         wrData = alu_res_i;
      end else if (rspAccept && ld_rsp_rd_i != '0) begin
         wrEn   = 1'b1;
         wrAddr = ld_rsp_rd_i;
         wrData = rspExt;
      end
   end

   // Next register contents: everything holds except the one written entry.
   always_comb begin
      for (int i = 1; i < NREG; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (wrEn) begin
         regs_d[wrAddr] = wrData;
      end
   end

   // Next scoreboard: an accepted response clears its register, a load that
   // issues sets its destination. The set comes last so that a register
   // cleared and re-claimed in the same cycle stays busy. x0 is never busy.
   always_comb begin
      busy_d = busy_q;
      if (rspAccept && ld_rsp_rd_i != '0) begin
         busy_d[ld_rsp_rd_i] = 1'b0;
      end
      if (ldFire) begin
         busy_d[rd_addr_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Register file and scoreboard state; synchronous reset wipes both.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         for (int i = 1; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         for (int i = 1; i < NREG; i++) begin
            regs_q[i] <= regs_d[i];
         end
         busy_q <= busy_d;
      end
   end

   // Read port 1: x0 is zero; with forwarding, a same-cycle write to the
   // addressed register is returned instead of the stored value.
   always_comb begin
      rs1Data = '0;
      if (rs1_addr_i != '0) begin
         rs1Data = regs_q[rs1_addr_i];
`ifdef REGFILE_BYPASS_EN
         if (wrEn && wrAddr == rs1_addr_i) begin
            rs1Data = wrData;
         end
`endif
      end
   end

   // Read port 2: same behaviour as port 1.
   always_comb begin
      rs2Data = '0;
      if (rs2_addr_i != '0) begin
         rs2Data = regs_q[rs2_addr_i];
`ifdef REGFILE_BYPASS_EN
         if (wrEn && wrAddr == rs2_addr_i) begin
            rs2Data = wrData;
         end
`endif
      end
   end

   assign rs1_rdata_o = rs1Data;
   assign rs2_rdata_o = rs2Data;

   logic            rspHeld_q;
   logic [4:0]      rspRdPrev_q;
   logic [XLEN-1:0] rspDataPrev_q;
   logic [1:0]      rspSizePrev_q;
   logic            rspUnsPrev_q;

   // Remember a response that was offered but refused, so the protocol
   // check next cycle can confirm the source kept it stable.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         rspHeld_q     <= 1'b0;
         rspRdPrev_q   <= '0;
         rspDataPrev_q <= '0;
         rspSizePrev_q <= '0;
         rspUnsPrev_q  <= 1'b0;
      end else begin
         rspHeld_q     <= ld_rsp_valid_i & ~ld_rsp_ready_o;
         rspRdPrev_q   <= ld_rsp_rd_i;
         rspDataPrev_q <= ld_rsp_data_i;
         rspSizePrev_q <= ld_rsp_size_i;
         rspUnsPrev_q  <= ld_rsp_unsigned_i;
      end
   end

   // Usage checks: no instruction is both an ALU write and a load, responses
   // only target registers with a load outstanding, and a refused response
   // is presented again unchanged.
   always_ff @(posedge clk_i) begin
      if (rst_n_i) begin
         assert (!(rd_wen_i && ld_issue_i));
         assert (!(rspAccept && ld_rsp_rd_i != '0 && !busy_q[ld_rsp_rd_i]));
         if (rspHeld_q) begin
            assert (ld_rsp_valid_i && ld_rsp_rd_i == rspRdPrev_q
                    && ld_rsp_data_i == rspDataPrev_q && ld_rsp_size_i == rspSizePrev_q
                    && ld_rsp_unsigned_i == rspUnsPrev_q);
         end
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
// Directed walk through the register file's main scenarios followed by a
// randomized run, all checked against an array-based model of the register
// file and load scoreboard kept in this bench.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic [4:0]  rs1_addr_i = '0;
   logic [4:0]  rs2_addr_i = '0;
   logic        rs1_used_i = 1'b0;
   logic        rs2_used_i = 1'b0;
   logic [63:0] rs1_rdata_o;
   logic [63:0] rs2_rdata_o;
   logic [4:0]  rd_addr_i = '0;
   logic        rd_wen_i = 1'b0;
   logic [63:0] alu_res_i = '0;
   logic        ld_issue_i = 1'b0;
   logic        ld_rsp_valid_i = 1'b0;
   logic        ld_rsp_ready_o;
   logic [4:0]  ld_rsp_rd_i = '0;
   logic [63:0] ld_rsp_data_i = '0;
   logic [1:0]  ld_rsp_size_i = '0;
   logic        ld_rsp_unsigned_i = 1'b0;
   logic        stall_o;

   // Free-running core clock.
   always #5 clk_i = ~clk_i;

   wb_regfile #(.XLEN(64), .NREG(32)) dut (
      .clk_i             (clk_i),
      .rst_n_i           (rst_n_i),
      .rs1_addr_i        (rs1_addr_i),
      .rs2_addr_i        (rs2_addr_i),
      .rs1_used_i        (rs1_used_i),
      .rs2_used_i        (rs2_used_i),
      .rs1_rdata_o       (rs1_rdata_o),
      .rs2_rdata_o       (rs2_rdata_o),
      .rd_addr_i         (rd_addr_i),
      .rd_wen_i          (rd_wen_i),
      .alu_res_i         (alu_res_i),
      .ld_issue_i        (ld_issue_i),
      .ld_rsp_valid_i    (ld_rsp_valid_i),
      .ld_rsp_ready_o    (ld_rsp_ready_o),
      .ld_rsp_rd_i       (ld_rsp_rd_i),
      .ld_rsp_data_i     (ld_rsp_data_i),
      .ld_rsp_size_i     (ld_rsp_size_i),
      .ld_rsp_unsigned_i (ld_rsp_unsigned_i),
      .stall_o           (stall_o)
   );

   logic [63:0] mRegs [32];
   bit          mBusy [32];
   int          compared = 0;
   int          mismatched = 0;

   logic        expStall;
   logic        expReady;
   logic [63:0] expRs1;
   logic [63:0] expRs2;
   logic [63:0] expExt;
   bit          expAluFire;
   bit          expAccept;
   bit          expLdFire;
   bit          holdRsp;

   // Load extension from the access size: keep the low 8<<size bits, then
   // set every higher bit when signed and the kept field's top bit is one.
   function automatic logic [63:0] extendModel(input logic [63:0] raw, input logic [1:0] size,
                                               input logic uns);
      int          bits;
      logic [63:0] mask;
      logic [63:0] val;
      bits = 8 << size;
      if (bits == 64) return raw;
      mask = (64'd1 << bits) - 64'd1;
      val  = raw & mask;
      if (!uns && raw[bits-1]) val = val | ~mask;
      return val;
   endfunction

   // A register looks busy to the issuing instruction if the scoreboard says
   // so, unless forwarding is on and a response for it is certain to be
   // taken this cycle (nothing but an ALU write to a real register can take
   // the write port away from it).
   function automatic bit seenBusy(input logic [4:0] a);
      if (a == 5'd0) return 1'b0;
      if (!mBusy[a]) return 1'b0;
      if (BYPASS && ld_rsp_valid_i && ld_rsp_rd_i == a && !(rd_wen_i && rd_addr_i != 5'd0))
         return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [63:0] readModel(input logic [4:0] a);
      if (a == 5'd0) return 64'd0;
      if (BYPASS && expAluFire && rd_addr_i == a) return alu_res_i;
      if (BYPASS && expAccept && ld_rsp_rd_i == a) return expExt;
      return mRegs[a];
   endfunction

   task automatic computeExpect();
      expStall   = (rs1_used_i && seenBusy(rs1_addr_i)) || (rs2_used_i && seenBusy(rs2_addr_i))
                   || ((rd_wen_i || ld_issue_i) && seenBusy(rd_addr_i));
      expAluFire = rd_wen_i && !expStall && rd_addr_i != 5'd0;
      expLdFire  = ld_issue_i && !expStall && rd_addr_i != 5'd0;
      expReady   = !expAluFire;
      expAccept  = ld_rsp_valid_i && expReady;
      expExt     = extendModel(ld_rsp_data_i, ld_rsp_size_i, ld_rsp_unsigned_i);
      expRs1     = readModel(rs1_addr_i);
      expRs2     = readModel(rs2_addr_i);
   endtask

   task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare every output against the model for the current inputs.
   task automatic checkOutput();
      computeExpect();
      checkValue("stall_o", {63'd0, stall_o}, {63'd0, expStall});
      checkValue("ld_rsp_ready_o", {63'd0, ld_rsp_ready_o}, {63'd0, expReady});
      checkValue("rs1_rdata_o", rs1_rdata_o, expRs1);
      checkValue("rs2_rdata_o", rs2_rdata_o, expRs2);
   endtask

   task automatic applyStimulus(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                                input logic u2, input logic [4:0] rd, input logic wen,
                                input logic [63:0] alu, input logic ldIss);
      rs1_addr_i = rs1;
      rs1_used_i = u1;
      rs2_addr_i = rs2;
      rs2_used_i = u2;
      rd_addr_i  = rd;
      rd_wen_i   = wen;
      alu_res_i  = alu;
      ld_issue_i = ldIss;
   endtask

   task automatic driveResponse(input logic v, input logic [4:0] rd, input logic [63:0] data,
                                input logic [1:0] size, input logic uns);
      ld_rsp_valid_i    = v;
      ld_rsp_rd_i       = rd;
      ld_rsp_data_i     = data;
      ld_rsp_size_i     = size;
      ld_rsp_unsigned_i = uns;
   endtask

   task automatic settle();
      #1;
      checkOutput();
   endtask

   // Advance one clock and apply the same cycle's effects to the model.
   task automatic tick();
      computeExpect();
      @(posedge clk_i);
      if (!rst_n_i) begin
         for (int i = 0; i < 32; i++) begin
            mRegs[i] = 64'd0;
            mBusy[i] = 1'b0;
         end
      end else begin
         if (expAluFire) mRegs[rd_addr_i] = alu_res_i;
         if (expAccept && ld_rsp_rd_i != 5'd0) begin
            mRegs[ld_rsp_rd_i] = expExt;
            mBusy[ld_rsp_rd_i] = 1'b0;
         end
         if (expLdFire) mBusy[rd_addr_i] = 1'b1;
      end
      @(negedge clk_i);
   endtask

   // Directed scenarios, then randomized traffic, then the summary.
   initial begin
      logic [4:0]  busyList [$];
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [4:0]  rd;
      int          kind;

      $display("[TB] start, bypass=%0d", BYPASS);
      @(negedge clk_i);
      tick();
      tick();
      rst_n_i = 1'b1;

      // Reset state
      applyStimulus(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 64'd0, 1'b0);
      settle();
      checkValue("reset_stall", {63'd0, stall_o}, 64'd0);
      checkValue("reset_ready", {63'd0, ld_rsp_ready_o}, 64'd1);
      tick();

      // ALU write x5, read it back; write x0 is discarded
      applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 64'h1234, 1'b0);
      settle();
      tick();
      applyStimulus(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 64'hFFFF, 1'b0);
      settle();
      checkValue("x5_read", rs1_rdata_o, 64'h1234);
      tick();
      applyStimulus(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 64'd0, 1'b0);
      settle();
      checkValue("x0_read", rs1_rdata_o, 64'd0);
      tick();

      // Load to x7, dependent reader stalls until the response
      applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 64'd0, 1'b1);
      settle();
      tick();
      for (int i = 0; i < 2; i++) begin
         applyStimulus(5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 64'd0, 1'b0);
         settle();
         checkValue("raw_x7_stall", {63'd0, stall_o}, 64'd1);
         tick();
      end
      driveResponse(1'b1, 5'd7, 64'h80, 2'd0, 1'b0);
      settle();
      checkValue("x7_rsp_cycle_stall", {63'd0, stall_o}, BYPASS ? 64'd0 : 64'd1);
      checkValue("x7_rsp_ready", {63'd0, ld_rsp_ready_o}, 64'd1);
      tick();
      driveResponse(1'b0, 5'd0, 64'd0, 2'd0, 1'b0);
      settle();
      checkValue("x7_after_stall", {63'd0, stall_o}, 64'd0);
      checkValue("x7_value", rs2_rdata_o, 64'hFFFF_FFFF_FFFF_FF80);
      tick();

      // ALU write to x3 collides with a response for x9
      applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0, 64'd0, 1'b1);
      settle();
      tick();
      applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 64'h3333, 1'b0);
      driveResponse(1'b1, 5'd9, 64'h1122_3344_5566_7788, 2'd3, 1'b0);
      settle();
      checkValue("collide_ready", {63'd0, ld_rsp_ready_o}, 64'd0);
      tick();
      applyStimulus(5'd3, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 64'd0, 1'b0);
      settle();
      checkValue("held_ready", {63'd0, ld_rsp_ready_o}, 64'd1);
      checkValue("x3_value", rs1_rdata_o, 64'h3333);
      tick();
      driveResponse(1'b0, 5'd0, 64'd0, 2'd0, 1'b0);
      settle();
      checkValue("x9_value", rs2_rdata_o, 64'h1122_3344_5566_7788);
      tick();

      // Word unsigned and half signed extension
      applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b0, 64'd0, 1'b1);
      settle();
      tick();
      applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b0, 64'd0, 1'b1);
      settle();
      tick();
      applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 64'd0, 1'b0);
      driveResponse(1'b1, 5'd10, 64'hDEADBEEF_80000001, 2'd2, 1'b1);
      settle();
      tick();
      driveResponse(1'b1, 5'd11, 64'h8001, 2'd1, 1'b0);
      settle();
      tick();
      driveResponse(1'b0, 5'd0, 64'd0, 2'd0, 1'b0);
      applyStimulus(5'd10, 1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 64'd0, 1'b0);
      settle();
      checkValue("word_unsigned", rs1_rdata_o, 64'h0000_0000_8000_0001);
      checkValue("half_signed", rs2_rdata_o, 64'hFFFF_FFFF_FFFF_8001);
      tick();

      // WAW against a pending load on x4, then clear and re-issue together
      applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b0, 64'd0, 1'b1);
      settle();
      tick();
      applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 64'h4444, 1'b0);
      settle();
      checkValue("waw_stall", {63'd0, stall_o}, 64'd1);
      checkValue("waw_ready", {63'd0, ld_rsp_ready_o}, 64'd1);
      tick();
      applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b0, 64'd0, 1'b1);
      driveResponse(1'b1, 5'd4, 64'h44, 2'd3, 1'b0);
      settle();
      checkValue("reissue_stall", {63'd0, stall_o}, BYPASS ? 64'd0 : 64'd1);
      tick();
      driveResponse(1'b0, 5'd0, 64'd0, 2'd0, 1'b0);
      applyStimulus(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 64'd0, 1'b0);
      settle();
      checkValue("set_wins_busy", {63'd0, stall_o}, BYPASS ? 64'd1 : 64'd0);
      tick();
      if (!BYPASS) begin
         applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b0, 64'd0, 1'b1);
         settle();
         tick();
      end

      // Reset with x4 busy and x5 = 7
      applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 64'd7, 1'b0);
      settle();
      tick();
      applyStimulus(5'd4, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 64'd0, 1'b0);
      settle();
      checkValue("pre_reset_busy", {63'd0, stall_o}, 64'd1);
      checkValue("pre_reset_x5", rs2_rdata_o, 64'd7);
      rst_n_i = 1'b0;
      tick();
      rst_n_i = 1'b1;
      settle();
      checkValue("post_reset_stall", {63'd0, stall_o}, 64'd0);
      checkValue("post_reset_x5", rs2_rdata_o, 64'd0);
      tick();

      // Randomized traffic; responses only target busy registers and a
      // refused response is held unchanged until taken.
      holdRsp = 1'b0;
      for (int c = 0; c < 500; c++) begin
         r1   = 5'($urandom_range(0, 31));
         r2   = 5'($urandom_range(0, 31));
         rd   = 5'($urandom_range(0, 31));
         kind = $urandom_range(0, 3);
         applyStimulus(r1, 1'($urandom_range(0, 1)), r2, 1'($urandom_range(0, 1)), rd,
                       kind == 1, {$urandom, $urandom}, kind >= 2);
         if (!holdRsp) begin
            busyList.delete();
            for (int i = 1; i < 32; i++) begin
               if (mBusy[i]) busyList.push_back(5'(i));
            end
            if (busyList.size() != 0 && $urandom_range(0, 2) != 0) begin
               driveResponse(1'b1, busyList[$urandom_range(0, busyList.size() - 1)],
                             {$urandom, $urandom}, 2'($urandom_range(0, 3)),
                             1'($urandom_range(0, 1)));
            end else begin
               driveResponse(1'b0, 5'($urandom_range(0, 31)), {$urandom, $urandom}, 2'd0, 1'b0);
            end
         end
         settle();
         holdRsp = ld_rsp_valid_i && !expAccept;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-side register file for the RV64 core: the other end of the execute datapath, consuming ALU results and load responses and driving rs1/rs2 operands back into the ALU. It holds the 31 writable integer registers with x0 hardwired to zero, and a load scoreboard that stalls issue on RAW/WAW hazards against outstanding loads. Load responses use a valid/ready handshake.

## Interface
- XLEN, 64, register width
- NREG, 32, architectural register count; index width is 5

- clk_i  in  1  core clock
- rst_n_i  in  1  synchronous active-low reset; one clock, reset is synchronous and active-low
- rs1_addr_i / rs2_addr_i  in  5  read addresses of the issuing instruction
- rs1_used_i / rs2_used_i  in  1  instruction actually reads that operand
- rs1_rdata_o / rs2_rdata_o  out  XLEN  combinational read data
- rd_addr_i  in  5  destination of the issuing instruction
- rd_wen_i  in  1  issuing instruction writes ALU result (alu_res_i) this cycle
- alu_res_i  in  XLEN  ALU result
- ld_issue_i  in  1  issuing instruction is a load targeting rd_addr_i
- ld_rsp_valid_i  in  1  load response valid
- ld_rsp_ready_o  out  1  load response accepted this cycle
- ld_rsp_rd_i  in  5  load response destination
- ld_rsp_data_i  in  XLEN  raw load data, right-aligned
- ld_rsp_size_i  in  2  0 byte, 1 half, 2 word, 3 double
- ld_rsp_unsigned_i  in  1  zero-extend instead of sign-extend
- stall_o  out  1  issuing instruction must be held

## Operation
- Storage: regs[1..31], XLEN each; reads of address 0 return 0; writes to address 0 discarded.
- Scoreboard busy[1..31]. stall_o = (rs1_used_i & busy[rs1]) | (rs2_used_i & busy[rs2]) | ((rd_wen_i | ld_issue_i) & busy[rd]); busy[0] reads 0.
- Issue fires when ~stall_o. Fired rd_wen_i with rd≠0: regs[rd] <= alu_res_i. Fired ld_issue_i with rd≠0: busy[rd] <= 1. rd_wen_i and ld_issue_i together is illegal (assertion).
- ld_rsp_ready_o = ~(rd_wen_i & ~stall_o & rd_addr_i≠0) — ALU writeback owns the single write port; load response waits.
- Accepted response (valid & ready): regs[ld_rsp_rd] <= extended data (if rd≠0); busy[ld_rsp_rd] <= 0.
- Extension: size selects low 8/16/32/64 bits; upper bits = unsigned ? 0 : top selected bit.
- Same-register set and clear in one cycle: set wins (busy stays 1).
- Response to a non-busy register: data still written, busy unchanged; flagged by assertion.

## Timing
- Reset (rst_n_i low at posedge): all regs 0, all busy 0. Outputs after reset: rdata 0, stall_o 0 unless inputs demand, ld_rsp_ready_o 1 unless ALU write fires.
- Writes land at posedge; without bypass, read data reflects the write from the following cycle.
- busy set at posedge of issue; dependent instruction stalls from the next cycle.
- Reset mid-operation: busy bits and registers cleared; an in-flight load response arriving after reset writes its data and leaves busy 0 (assertion only).
- Handshake: ld_rsp_* must stay stable while valid & ~ready.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle forwarding. Read of an address being written this cycle (fired ALU write or accepted load response, rd≠0) returns the write data; a busy bit being cleared this cycle reads as 0 for stall_o, so a load-dependent instruction issues in the response cycle.
- Undefined: no forwarding; read data and busy are pure register state; dependent instruction issues one cycle after the response.

## Test plan
- Reset, then write x5=0x1234 via ALU; read rs1=x5 next cycle -> 0x1234; write x0=0xFFFF -> reads of x0 return 0.
- Load issue rd=x7, then instruction with rs2=x7 used -> stall_o=1 until response 0x80 size0 signed accepted; x7 = 0xFFFFFFFFFFFFFF80; stall drops same cycle with REGFILE_BYPASS_EN, one cycle later without.
- ALU write x3 and load response for x9 in same cycle -> ld_rsp_ready_o=0, response held, accepted next cycle; both values correct.
- Response size2 unsigned data 0xDEADBEEF_80000001 -> rd = 0x0000000080000001; size1 signed 0x8001 -> 0xFFFFFFFFFFFF8001.
- WAW: load pending on x4, ALU writing x4 -> stall_o=1; response clears busy in same cycle as new load issue to x4 -> busy stays 1.
- Assert rst_n_i low with x4 busy and x5=7 -> busy clear, x5 reads 0, stall_o=0.
